// File: rtl/stopwatch_lap_recorder.sv
// stopwatch_lap_recorder
//   Prescaled stopwatch with a start/pause/stop FSM, lap capture into a small
//   buffer, and sequential read-back of the captured laps once stopped.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   start/pause/stop  command pulses (priority stop > pause > start)
//   lap               capture unit_count into the lap buffer (RUN/PAUSED)
//   rd_req            pop next lap entry (STOPPED only)
//   tick              one-cycle pulse per elapsed unit
//   unit_count        elapsed units (wraps)
//   state             0 IDLE, 1 RUN, 2 PAUSED, 3 STOPPED
//   lap_count         entries stored, 0..LAP_DEPTH
//   full              lap_count == LAP_DEPTH (combinational)
//   overflow          sticky: a lap was dropped while full
//   rd_data/rd_valid/rd_last  read-back entry, valid pulse, final-entry flag
module stopwatch_lap_recorder #(
  parameter int CLOCK_CYCLES = 50_000_000,
  parameter int COUNT_W      = 8,
  parameter int LAP_DEPTH    = 16,
  parameter int ADDR_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic               lap,
  input  logic               rd_req,
  output logic               tick,
  output logic [COUNT_W-1:0] unit_count,
  output logic [1:0]         state,
  output logic [ADDR_W:0]    lap_count,
  output logic               full,
  output logic               overflow,
  output logic [COUNT_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               rd_last
);

  localparam int               PW      = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [PW-1:0]    PS_LAST = PW'(CLOCK_CYCLES - 1);
  localparam logic [ADDR_W:0]  DEPTH   = (ADDR_W + 1)'(LAP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_STOPPED = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [COUNT_W-1:0] unit_q, unit_d;
  logic               tick_q, tick_d;
  logic [ADDR_W:0]    lap_cnt_q, lap_cnt_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
  logic               ovf_q, ovf_d;
  logic [COUNT_W-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic               wr_en;

  logic [COUNT_W-1:0] lap_mem [LAP_DEPTH];

  // Next state. The highest-priority asserted command wins even when it has
  // no effect in the current state, so e.g. start+pause in IDLE does nothing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!stop && !pause && start) state_d = S_RUN;
      S_RUN:     if (stop) state_d = S_STOPPED;
                 else if (pause) state_d = S_PAUSED;
      S_PAUSED:  if (stop) state_d = S_STOPPED;
                 else if (!pause && start) state_d = S_RUN;
      S_STOPPED: if (!stop && !pause && start) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath. Counting, lap capture and read-back all key off the current
  // state, so a terminal count on the same edge as pause/stop still counts.
  always_comb begin
    presc_d    = presc_q;
    unit_d     = unit_q;
    tick_d     = 1'b0;
    lap_cnt_d  = lap_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    wr_en      = 1'b0;

    if (state_q == S_RUN) begin
      if (presc_q == PS_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        unit_d  = unit_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // Lap stores the registered (pre-increment) count.
    if (lap && (state_q == S_RUN || state_q == S_PAUSED)) begin
      if (lap_cnt_q == DEPTH) begin
        ovf_d = 1'b1;
      end else begin
        wr_en     = 1'b1;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        lap_cnt_d = lap_cnt_q + 1'b1;
      end
    end

    if (state_q == S_STOPPED && rd_req && rd_ptr_q < lap_cnt_q) begin
      rd_data_d  = lap_mem[rd_ptr_q[ADDR_W-1:0]];
      rd_valid_d = 1'b1;
      rd_last_d  = (rd_ptr_q == lap_cnt_q - 1'b1);
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end

    // STOPPED -> IDLE discards the session.
    if (state_q == S_STOPPED && state_d == S_IDLE) begin
      presc_d   = '0;
      unit_d    = '0;
      lap_cnt_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      unit_q     <= '0;
      tick_q     <= 1'b0;
      lap_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      unit_q     <= unit_d;
      tick_q     <= tick_d;
      lap_cnt_q  <= lap_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Buffer storage carries no reset; lap_count defines what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) lap_mem[wr_ptr_q] <= unit_q;
  end

  assign tick       = tick_q;
  assign unit_count = unit_q;
  assign state      = state_q;
  assign lap_count  = lap_cnt_q;
  assign full       = (lap_cnt_q == DEPTH);
  assign overflow   = ovf_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_last    = rd_last_q;

endmodule
